fa_resp_checker: RTL and testbench
==================================

# fa_resp_checker

Synthesizable response checker for the 1-bit full adder `src2`. It samples each applied input vector together with the adder's sum and carry. Each sample is compared against a golden full-add, and the block counts mismatches and tracks coverage of all 8 input combinations. It flags done and pass once exhaustive coverage is reached, or flags a timeout. It sits on the observation side of the adder, opposite the stimulus driver, for bench and on-chip self-test use.

## Interface
Parameters:
- `ERR_CNT_W`, default 8: width of the mismatch counter.
- `TIMEOUT`, default 64: maximum number of RUN cycles allowed before reaching full coverage. Legal range is 8..2^16.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle pulse that arms a new check run.
- `in_valid`, input, 1: the `a/b/c/x/y` values are a settled sample this cycle.
- `a`, `b`, `c`, input, 1 each: adder operands and carry-in, as applied to the adder.
- `x`, input, 1: adder sum output.
- `y`, input, 1: adder carry output.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high while in DONE.
- `pass`, output, 1: valid when `done`=1. Means full coverage, zero errors, no timeout.
- `timeout`, output, 1: the run ended because the `TIMEOUT` limit expired.
- `cov_mask`, output, 8: bit i set once vector i = {a,b,c} has been sampled.
- `err_cnt`, output, ERR_CNT_W: mismatch count. Saturates at all-ones.
- `first_err_valid`, output, 1: at least one mismatch has been captured.
- `first_err_vec`, output, 3: the {a,b,c} value of the first mismatching sample.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset value of every state and output register: state=IDLE and all outputs 0.
- IDLE:
  - `start`=1 clears `cov_mask`, `err_cnt`, the first-error fields, `timeout` and the cycle counter, then goes to RUN.
  - `in_valid` is ignored.
- RUN:
  - On `in_valid`=1, compute idx={a,b,c}.
  - Expected sum = a^b^c. Expected carry = ab|bc|ac.
  - A mismatch is declared if either `x` or `y` differs from its expected value.
  - On mismatch: `err_cnt` increments unless already saturated.
  - On the first mismatch of the run only: capture idx into `first_err_vec` and set `first_err_valid`.
  - `cov_mask[idx]` is set regardless of whether the sample passed.
  - Repeated vectors are re-checked and their errors counted, but coverage is unchanged.
- RUN exit:
  - If the next `cov_mask` value, including the current sample, is all-ones, go to DONE.
  - In that case `pass` = (next `err_cnt` == 0).
  - Otherwise, if the cycle counter equals `TIMEOUT`-1, go to DONE with `timeout`=1 and `pass`=0.
  - Coverage completion takes priority over timeout when both occur in the same cycle.
- DONE:
  - All results hold.
  - `start`=1 re-arms exactly as in IDLE.
  - `in_valid` is ignored.
- `start` while in RUN is ignored and does not restart the run.
- The cycle counter counts every RUN cycle, whether or not `in_valid` is high, and is cleared on entry to RUN.

## Timing
- All outputs are registered.
- A sample taken at edge N is reflected in `cov_mask`, `err_cnt` and the first-error fields after edge N.
- RUN/DONE transitions occur at the same edge, so `done`=1 and the final `pass` are visible in the cycle after the completing sample.
- `busy` goes to 1 in the cycle after `start`. A sample presented in that cycle is accepted.
- Minimum run length is 8 samples with `in_valid` continuously high. Done then appears 1 cycle after the 8th sample.
- Asserting `rst_n` low at any time, including mid-RUN, returns the block to IDLE asynchronously with all outputs 0. No partial results are retained.

## Structure
- Package `fa_chk_pkg`:
  - `state_t` enum (IDLE, RUN, DONE).
  - Constant `NUM_VEC`=8.
  - Function `fa_golden(a,b,c)`, returning {carry,sum}.
- Sub-module `fa_golden_model`: purely combinational. Takes a/b/c and produces exp_x/exp_y by calling `fa_golden`. It is instantiated once in `fa_resp_checker` and reused by the bench scoreboard.
- The top level contains the FSM, coverage register, saturating counter, timeout counter and first-error capture.

## Test plan
- Correct exhaustive run: drive `start`, then the 8 vectors 000..111 with correct x/y, `in_valid`=1 → `done`=1 one cycle after vector 111, `pass`=1, `cov_mask`=8'hFF, `err_cnt`=0, `first_err_valid`=0.
- Faulty DUT: force `y`=0 whenever a=b=1 → `err_cnt`=2, `first_err_vec`=3'b110, `pass`=0, `done`=1.
- Incomplete coverage: apply only vectors 000..110, repeated, with `TIMEOUT`=16 → `done` in the cycle after RUN cycle 15, `timeout`=1, `pass`=0, `cov_mask`=8'h7F.
- Coverage/timeout collision: the 8th unique vector lands in RUN cycle `TIMEOUT`-1 → `pass`=1, `timeout`=0.
- Saturation: with `ERR_CNT_W`=2, apply 6 erroneous samples before completing coverage → `err_cnt`=3, with no wrap to 0.
- Reset mid-run: pull `rst_n` low after 4 samples → all outputs 0 immediately. After release, `start` plus 8 correct vectors → `pass`=1.

Source files
------------

// File: rtl/fa_chk_pkg.sv
// fa_chk_pkg: shared types and the golden full-add reference used by the
// response checker and its bench.
//   state_t   : checker FSM states
//   NUM_VEC   : number of distinct {a,b,c} input vectors
//   fa_golden : returns {carry, sum} for a 1-bit full add
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;

  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
    return {(a & b) | (b & c) | (a & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// fa_golden_model: purely combinational reference full adder.
//   a, b, c : operands and carry-in
//   exp_x   : expected sum
//   exp_y   : expected carry
module fa_golden_model
  import fa_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_x,
  output logic exp_y
);

  assign {exp_y, exp_x} = fa_golden(a, b, c);

endmodule

// File: rtl/fa_resp_checker.sv
// fa_resp_checker: observes a 1-bit full adder, compares every valid sample
// against the golden model, counts mismatches, tracks coverage of all eight
// {a,b,c} vectors and reports done/pass or timeout.
//   clk, rst_n      : clock, async active-low reset
//   start           : one-cycle pulse arming a run (ignored while busy)
//   in_valid        : a/b/c/x/y hold a settled sample this cycle
//   a, b, c         : adder inputs; x, y : adder sum, carry
//   busy, done      : in RUN / in DONE
//   pass            : full coverage, no errors, no timeout (valid with done)
//   timeout         : run ended on the cycle limit
//   cov_mask        : bit {a,b,c} set once that vector was sampled
//   err_cnt         : saturating mismatch count
//   first_err_valid : a mismatch has been captured
//   first_err_vec   : {a,b,c} of the first mismatch
module fa_resp_checker
  import fa_chk_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 x,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_VEC-1:0]   cov_mask,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 first_err_valid,
  output logic [2:0]           first_err_vec
);

  // TIMEOUT-1 is the largest value the cycle counter ever has to hold.
  localparam int              CYC_W    = $clog2(TIMEOUT);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [NUM_VEC-1:0]     cov_q, cov_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   fe_q, fe_d;
  logic [2:0]             fev_q, fev_d;
  logic                   to_q, to_d;
  logic                   pass_q, pass_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;

  logic       exp_x, exp_y;
  logic [2:0] idx;
  logic       mism;

  assign idx  = {a, b, c};
  assign mism = (x != exp_x) || (y != exp_y);

  fa_golden_model u_gold (
    .a     (a),
    .b     (b),
    .c     (c),
    .exp_x (exp_x),
    .exp_y (exp_y)
  );

  always_comb begin
    state_d = state_q;
    cov_d   = cov_q;
    err_d   = err_q;
    fe_d    = fe_q;
    fev_d   = fev_q;
    to_d    = to_q;
    pass_d  = pass_q;
    cyc_d   = cyc_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cov_d   = '0;
          err_d   = '0;
          fe_d    = 1'b0;
          fev_d   = '0;
          to_d    = 1'b0;
          pass_d  = 1'b0;
          cyc_d   = '0;
        end
      end
      RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (in_valid) begin
          if (mism) begin
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
            if (!fe_q) begin
              fe_d  = 1'b1;
              fev_d = idx;
            end
          end
          cov_d[idx] = 1'b1;
        end
        // Completion wins over the cycle limit when both land together.
        if (&cov_d) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else if (cyc_q == CYC_LAST) begin
          state_d = DONE;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cov_q   <= '0;
      err_q   <= '0;
      fe_q    <= 1'b0;
      fev_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_d;
      err_q   <= err_d;
      fe_q    <= fe_d;
      fev_q   <= fev_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign timeout         = to_q;
  assign cov_mask        = cov_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fe_q;
  assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Bench for fa_resp_checker: two instances share stimulus (8-bit and 2-bit
// error counters, TIMEOUT=16). A bench model pushes expected post-edge
// results into a queue as each cycle is driven; a monitor pops and compares.
module tb_fa_resp_checker;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, x = 1'b0, y = 1'b0;

  logic       busy1, done1, pass1, to1, fe1;
  logic [7:0] cov1, err1;
  logic [2:0] fev1;
  logic       busy2, done2, pass2, to2, fe2;
  logic [7:0] cov2;
  logic [1:0] err2;
  logic [2:0] fev2;

  logic ga = 1'b0, gb = 1'b0, gc = 1'b0, gx, gy;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fa_resp_checker #(.ERR_CNT_W(8), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .x(x), .y(y),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(to1),
    .cov_mask(cov1), .err_cnt(err1),
    .first_err_valid(fe1), .first_err_vec(fev1)
  );

  fa_resp_checker #(.ERR_CNT_W(2), .TIMEOUT(TO)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .x(x), .y(y),
    .busy(busy2), .done(done2), .pass(pass2), .timeout(to2),
    .cov_mask(cov2), .err_cnt(err2),
    .first_err_valid(fe2), .first_err_vec(fev2)
  );

  fa_golden_model u_gold (.a(ga), .b(gb), .c(gc), .exp_x(gx), .exp_y(gy));

  typedef struct {
    int         tag;
    logic [3:0] flags;  // busy, done, pass, timeout
    logic [7:0] cov;
    logic [7:0] err8;
    logic [1:0] err2;
    logic [3:0] fe;     // valid, vec
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // bench model state
  int         m_state = 0;  // 0 idle, 1 run, 2 done
  logic [7:0] m_cov = '0;
  int         m_err = 0;
  logic       m_fe = 1'b0;
  logic [2:0] m_fev = '0;
  logic       m_to = 1'b0, m_pass = 1'b0;
  int         m_cyc = 0;

  task automatic model_reset();
    m_state = 0; m_cov = '0; m_err = 0; m_fe = 1'b0; m_fev = '0;
    m_to = 1'b0; m_pass = 1'b0; m_cyc = 0;
  endtask

  // Drive one cycle; fx/fy flip the correct sum/carry to emulate a faulty adder.
  task automatic step(input bit st, input bit v, input int vec, input bit fx, input bit fy);
    exp_t       e;
    logic [2:0] vb;
    logic [1:0] sum;
    @(negedge clk);
    vb  = vec[2:0];
    sum = 2'(vb[2]) + 2'(vb[1]) + 2'(vb[0]);
    start = st; in_valid = v;
    a = vb[2]; b = vb[1]; c = vb[0];
    x = sum[0] ^ fx; y = sum[1] ^ fy;
    if (m_state != 1) begin
      if (st) begin
        m_cov = '0; m_err = 0; m_fe = 1'b0; m_fev = '0;
        m_to = 1'b0; m_pass = 1'b0; m_cyc = 0; m_state = 1;
      end
    end else begin
      if (v) begin
        if (fx || fy) begin
          m_err++;
          if (!m_fe) begin m_fe = 1'b1; m_fev = vb; end
        end
        m_cov[vb] = 1'b1;
      end
      if (m_cov == 8'hFF) begin
        m_state = 2; m_pass = (m_err == 0);
      end else if (m_cyc == TO - 1) begin
        m_state = 2; m_to = 1'b1; m_pass = 1'b0;
      end
      m_cyc++;
    end
    e.tag   = cyc_cnt + 1;
    e.flags = {m_state == 1, m_state == 2, m_pass, m_to};
    e.cov   = m_cov;
    e.err8  = (m_err > 255) ? 8'hFF : 8'(m_err);
    e.err2  = (m_err > 3) ? 2'd3 : 2'(m_err);
    e.fe    = {m_fe, m_fev};
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].tag <= cyc_cnt) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if ({busy1, done1, pass1, to1} !== mon_e.flags) begin
        n_err++; $display("FAIL flags8 cyc %0d got %b exp %b", cyc_cnt, {busy1, done1, pass1, to1}, mon_e.flags);
      end
      n_vec++;
      if ({busy2, done2, pass2, to2} !== mon_e.flags) begin
        n_err++; $display("FAIL flags2 cyc %0d got %b exp %b", cyc_cnt, {busy2, done2, pass2, to2}, mon_e.flags);
      end
      n_vec++;
      if (cov1 !== mon_e.cov || cov2 !== mon_e.cov) begin
        n_err++; $display("FAIL cov cyc %0d got %h/%h exp %h", cyc_cnt, cov1, cov2, mon_e.cov);
      end
      n_vec++;
      if (err1 !== mon_e.err8) begin
        n_err++; $display("FAIL err8 cyc %0d got %0d exp %0d", cyc_cnt, err1, mon_e.err8);
      end
      n_vec++;
      if (err2 !== mon_e.err2) begin
        n_err++; $display("FAIL err2 cyc %0d got %0d exp %0d", cyc_cnt, err2, mon_e.err2);
      end
      n_vec++;
      if ({fe1, fev1} !== mon_e.fe || {fe2, fev2} !== mon_e.fe) begin
        n_err++; $display("FAIL first_err cyc %0d got %h/%h exp %h", cyc_cnt, {fe1, fev1}, {fe2, fev2}, mon_e.fe);
      end
    end
  end

  task automatic test_reset();
    #1;
    n_vec++;
    if ({busy1, done1, pass1, to1, cov1, err1, fe1, fev1} !== '0 ||
        {busy2, done2, pass2, to2, cov2, err2, fe2, fev2} !== '0) begin
      n_err++; $display("FAIL reset_state got %h exp 0", {busy1, done1, pass1, to1, cov1, err1, fe1, fev1});
    end
    @(negedge clk); rst_n = 1'b1;
    // in_valid while idle must be ignored
    step(0, 1, 3, 1, 0);
    idle_inputs();
  endtask

  task automatic test_golden();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] s;
      v = 3'(i);
      ga = v[2]; gb = v[1]; gc = v[0];
      s = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #1;
      n_vec++;
      if ({gy, gx} !== s) begin
        n_err++; $display("FAIL golden vec %b got %b exp %b", v, {gy, gx}, s);
      end
    end
  endtask

  task automatic test_exhaustive();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, i, 0, 0);
    step(0, 0, 0, 0, 0);
    idle_inputs();
    n_vec++;
    if ({done1, pass1, to1, cov1, err1, fe1} !== {3'b110, 8'hFF, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL exhaustive got d%b p%b t%b cov %h err %0d fe %b exp 1 1 0 ff 0 0",
                        done1, pass1, to1, cov1, err1, fe1);
    end
  endtask

  task automatic test_faulty();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, i, 0, (i >= 6));
    idle_inputs();
    n_vec++;
    if ({done1, pass1, err1, fe1, fev1} !== {2'b10, 8'd2, 1'b1, 3'b110}) begin
      n_err++; $display("FAIL faulty got d%b p%b err %0d fev %b exp 1 0 2 110", done1, pass1, err1, fev1);
    end
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) step(0, 1, k % 7, 0, 0);
    idle_inputs();
    n_vec++;
    if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL timeout_early got done %b busy %b exp 0 1", done1, busy1);
    end
    step(0, 1, 15 % 7, 0, 0);
    idle_inputs();
    n_vec++;
    if ({done1, pass1, to1, cov1} !== {3'b101, 8'h7F}) begin
      n_err++; $display("FAIL timeout got d%b p%b t%b cov %h exp 1 0 1 7f", done1, pass1, to1, cov1);
    end
  endtask

  task automatic test_collision();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, i, 0, 0);
    idle_inputs();
    n_vec++;
    if ({done1, pass1, to1} !== 3'b110) begin
      n_err++; $display("FAIL collision got d%b p%b t%b exp 1 1 0", done1, pass1, to1);
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 1, 0);
    for (int i = 1; i < 8; i++) step(0, 1, i, 0, 0);
    idle_inputs();
    n_vec++;
    if ({err2, err1, done2, pass2} !== {2'd3, 8'd6, 2'b10}) begin
      n_err++; $display("FAIL saturation got err2 %0d err8 %0d d%b p%b exp 3 6 1 0", err2, err1, done2, pass2);
    end
  endtask

  task automatic test_back_to_back();
    // start during RUN must not restart the run
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, i, 0, 0);
    for (int i = 3; i < 8; i++) step(0, 1, i, 0, 0);
    // in DONE: sample ignored, then re-arm straight into a new run
    step(0, 1, 5, 1, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) step(0, 1, i, 0, 0);
    idle_inputs();
    n_vec++;
    if ({done1, pass1, err1} !== {2'b11, 8'd0}) begin
      n_err++; $display("FAIL back_to_back got d%b p%b err %0d exp 1 1 0", done1, pass1, err1);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, i, 1, 0);
    idle_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({busy1, done1, pass1, to1, cov1, err1, fe1, fev1} !== '0 ||
        {busy2, done2, pass2, to2, cov2, err2, fe2, fev2} !== '0) begin
      n_err++; $display("FAIL reset_mid got %h exp 0", {busy1, done1, pass1, to1, cov1, err1, fe1, fev1});
    end
    @(negedge clk); rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, i, 0, 0);
    idle_inputs();
    n_vec++;
    if ({done1, pass1, cov1, err1} !== {2'b11, 8'hFF, 8'd0}) begin
      n_err++; $display("FAIL reset_rerun got d%b p%b cov %h err %0d exp 1 1 ff 0", done1, pass1, cov1, err1);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_exhaustive();
    test_faulty();
    test_timeout();
    test_collision();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
